multi_channel_strobe_counter: RTL and testbench
===============================================

// Module: multi_channel_strobe_counter
// PURPOSE
//  N independent programmable strobe counters sharing one clock and one config port.
//  Each channel emits a 1-cycle strobe every PERIOD enabled ticks (periodic) or once (one-shot).
//  Period changes are shadowed and applied only at terminal count, so there are no short or long glitch periods.
//  Sits between clock-enable/tick sources and timers, baud generators and LED/PWM schedulers.
// PARAMETERS
//  WIDTH     25  counter and period width in bits (>=2)
//  CHANNELS  4   number of independent channels (1..16)
//  CH_W      2   channel index width, must be >= clog2(CHANNELS), min 1
// PORTS
//  clk          in   1                rising-edge clock
//  rst          in   1                asynchronous reset, active-low
//  enable       in   CHANNELS         per-channel tick qualifier; bit i advances channel i
//  cfg_valid    in   1                config write request
//  cfg_ready    out  1                config accepted when cfg_valid && cfg_ready
//  cfg_chan     in   CH_W             target channel
//  cfg_period   in   WIDTH            new period; 0 = channel disabled
//  cfg_oneshot  in   1                1 = one-shot mode, 0 = periodic
//  cfg_arm      in   1                1 = (re)arm channel: restart count at 1 immediately
//  strobe       out  CHANNELS         1-cycle pulse per terminal count
//  done         out  CHANNELS         one-shot finished flag (sticky until re-armed)
// BEHAVIOUR
//  Reset (rst==0, async): all counters=1, period=0, shadow=0, mode=periodic, armed=0;
//   strobe=0, done=0, cfg_ready=0. cfg_ready rises 1 cycle after rst deasserts; all outputs registered.
//  Count: counter starts at 1. On enable[i] && armed && period!=0:
//   - counter==period: strobe[i]=1 next cycle, counter<=1 (terminal tick).
//   - otherwise counter<=counter+1. strobe[i]=0 on any non-terminal cycle.
//   So the strobe is exactly every PERIOD enabled ticks; latency terminal tick->strobe = 1 cycle.
//  period==1: strobe every enabled tick (continuous high under continuous enable).
//  period==0: channel idle, no strobes, counter held at 1.
//  Counter above period (defensive): treated as terminal; strobe, then reload to 1.
//  Config handshake: a write is accepted in the cycle with cfg_valid && cfg_ready.
//   cfg_ready is 1 except in the single cycle after an accepted write (max 1 write per 2 cycles).
//   cfg_chan >= CHANNELS: write accepted and discarded.
//  Accepted write with cfg_arm=1: period<=cfg_period, mode<=cfg_oneshot, counter<=1, armed<=1, done<=0.
//   A terminal tick in the same cycle is lost (arm wins); no strobe.
//  Accepted write with cfg_arm=0: goes to shadow (period+mode) with pending=1.
//   Shadow is applied at the next terminal tick, or immediately if the channel is idle (period==0 or !armed).
//   A later write overwrites the pending shadow (last write wins).
//  One-shot: at the terminal tick, strobe fires once, armed<=0, done<=1.
//   Pending shadow is applied at that same tick. Re-arm only via cfg_arm.
//  Periodic: armed persists; done stays 0.
//  enable bits for unarmed/idle channels are ignored. Channels are fully independent.
// CONFIGURATION
//  MULTI_CHANNEL_STROBE_COUNT_OUT_EN defined: adds output port
//   count_out CHANNELS*WIDTH, live counter values, channel i at [i*WIDTH +: WIDTH]; reset value 1 each.
//  Not defined: port absent; counters internal only. Strobe/done behaviour identical either way.
// TESTING
//  1 Reset: rst low mid-count, enable=all-1s -> strobe=0, done=0, cfg_ready=0 during reset;
//    cfg_ready=1 one cycle after release.
//  2 Periodic: ch0 arm period=5, enable[0] held 1 -> strobe[0] at cycles 5,10,15 after arm; each 1 cycle wide.
//  3 Gapped enable: ch1 period=3, enable[1] toggling 1,0 -> strobe[1] every 6 clocks; other channels silent.
//  4 Shadow update: ch0 period=8, write period=3 (arm=0) at count 2 ->
//    current period completes at 8 ticks, then strobes every 3.
//  5 One-shot: ch2 arm oneshot period=4 -> single strobe after 4 ticks, done[2]=1 sticky;
//    re-arm clears done and restarts.
//  6 Edges: period=1 -> strobe each enabled tick; period=0 -> none;
//    cfg_arm same cycle as terminal tick -> no strobe, count restarts at 1.

Source files
------------

// File: rtl/multi_channel_strobe_counter.sv
// N independent programmable strobe counters sharing one clock and one config port.
// Optional port count_out is added when MULTI_CHANNEL_STROBE_COUNT_OUT_EN is defined.
module multi_channel_strobe_counter #(
  parameter int unsigned WIDTH    = 25,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic                cfg_oneshot,
  input  logic                cfg_arm,
  output logic [CHANNELS-1:0] strobe,
  output logic [CHANNELS-1:0] done
`ifdef MULTI_CHANNEL_STROBE_COUNT_OUT_EN
  ,
  output logic [CHANNELS*WIDTH-1:0] count_out
`endif
);

  logic accept;
  assign accept = cfg_valid && cfg_ready;

  // Ready drops for exactly one cycle after each accepted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_ready <= 1'b0;
    end else begin
      cfg_ready <= !accept;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam int unsigned Idx = i;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             mode_q, mode_d;
    logic             shadow_mode_q, shadow_mode_d;
    logic             pending_q, pending_d;
    logic             armed_q, armed_d;
    logic             done_q, done_d;
    logic             strobe_q, strobe_d;
    logic             wr, active, term, idle;

    assign wr     = accept && (32'(cfg_chan) == Idx);
    assign active = enable[i] && armed_q && (period_q != '0);
    // A counter above its period is treated as terminal so it can never run away.
    assign term   = active && (cnt_q >= period_q);
    assign idle   = !armed_q || (period_q == '0);

    always_comb begin
      cnt_d         = cnt_q;
      period_d      = period_q;
      mode_d        = mode_q;
      shadow_d      = shadow_q;
      shadow_mode_d = shadow_mode_q;
      pending_d     = pending_q;
      armed_d       = armed_q;
      done_d        = done_q;
      strobe_d      = 1'b0;

      if (period_q == '0) begin
        cnt_d = WIDTH'(1);
      end else if (active) begin
        cnt_d = term ? WIDTH'(1) : cnt_q + WIDTH'(1);
      end

      if (term) begin
        strobe_d = 1'b1;
        if (mode_q) begin
          armed_d = 1'b0;
          done_d  = 1'b1;
        end
        if (pending_q) begin
          period_d  = shadow_q;
          mode_d    = shadow_mode_q;
          pending_d = 1'b0;
        end
      end

      if (wr) begin
        if (cfg_arm) begin
          // Arm wins over a coincident terminal tick: the strobe is dropped.
          period_d  = cfg_period;
          mode_d    = cfg_oneshot;
          cnt_d     = WIDTH'(1);
          armed_d   = 1'b1;
          done_d    = 1'b0;
          pending_d = 1'b0;
          strobe_d  = 1'b0;
        end else if (idle || term) begin
          period_d  = cfg_period;
          mode_d    = cfg_oneshot;
          pending_d = 1'b0;
        end else begin
          shadow_d      = cfg_period;
          shadow_mode_d = cfg_oneshot;
          pending_d     = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q         <= WIDTH'(1);
        period_q      <= '0;
        shadow_q      <= '0;
        mode_q        <= 1'b0;
        shadow_mode_q <= 1'b0;
        pending_q     <= 1'b0;
        armed_q       <= 1'b0;
        done_q        <= 1'b0;
        strobe_q      <= 1'b0;
      end else begin
        cnt_q         <= cnt_d;
        period_q      <= period_d;
        shadow_q      <= shadow_d;
        mode_q        <= mode_d;
        shadow_mode_q <= shadow_mode_d;
        pending_q     <= pending_d;
        armed_q       <= armed_d;
        done_q        <= done_d;
        strobe_q      <= strobe_d;
      end
    end

    assign strobe[i] = strobe_q;
    assign done[i]   = done_q;
`ifdef MULTI_CHANNEL_STROBE_COUNT_OUT_EN
    assign count_out[i*WIDTH +: WIDTH] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_multi_channel_strobe_counter.sv
// Randomized and directed bench for multi_channel_strobe_counter against a
// countdown-style reference model of the strobe channels.
module tb_multi_channel_strobe_counter;
  localparam int W  = 25;
  localparam int CH = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] en;
  logic          cv, cos, carm;
  logic [CW-1:0] cch;
  logic [W-1:0]  cper;
  logic          cfg_ready;
  logic [CH-1:0] strobe, done;
`ifdef MULTI_CHANNEL_STROBE_COUNT_OUT_EN
  logic [CH*W-1:0] count_out;
`endif

  multi_channel_strobe_counter #(.WIDTH(W), .CHANNELS(CH), .CH_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (en),
    .cfg_valid   (cv),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cch),
    .cfg_period  (cper),
    .cfg_oneshot (cos),
    .cfg_arm     (carm),
    .strobe      (strobe),
    .done        (done)
`ifdef MULTI_CHANNEL_STROBE_COUNT_OUT_EN
    ,
    .count_out   (count_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: each live channel tracks ticks remaining until its next strobe.
  int unsigned   m_per[CH], m_rem[CH], m_sh_per[CH];
  bit            m_mode[CH], m_armed[CH], m_pend[CH], m_sh_mode[CH];
  logic [CH-1:0] m_strobe, m_done;
  bit            m_ready;
  int            cyc;
  int            n_chk, n_fail;
  int            q[$];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_per[c] = 0; m_rem[c] = 0; m_sh_per[c] = 0;
      m_mode[c] = 0; m_armed[c] = 0; m_pend[c] = 0; m_sh_mode[c] = 0;
    end
    m_strobe = '0;
    m_done   = '0;
    m_ready  = 1'b0;
  endtask

  // Predict the effect of the current inputs, then advance one clock.
  task automatic step();
    bit acc;
    logic [CH-1:0] nstr;
    acc  = cv && m_ready;
    nstr = '0;
    for (int c = 0; c < CH; c++) begin
      bit wr, term;
      wr   = acc && (int'(cch) == c);
      term = 0;
      if (en[c] && m_armed[c] && m_per[c] != 0) begin
        m_rem[c] = m_rem[c] - 1;
        if (m_rem[c] == 0) begin
          term    = 1;
          nstr[c] = 1'b1;
          if (m_mode[c]) begin
            m_armed[c] = 0;
            m_done[c]  = 1'b1;
          end
          if (m_pend[c]) begin
            m_per[c]  = m_sh_per[c];
            m_mode[c] = m_sh_mode[c];
            m_pend[c] = 0;
          end
          m_rem[c] = m_per[c];
        end
      end
      if (wr) begin
        if (carm) begin
          m_per[c] = cper; m_mode[c] = cos; m_armed[c] = 1; m_done[c] = 1'b0;
          m_pend[c] = 0; m_rem[c] = cper; nstr[c] = 1'b0;
        end else if (term || !m_armed[c] || m_per[c] == 0) begin
          m_per[c] = cper; m_mode[c] = cos; m_rem[c] = cper;
        end else begin
          m_sh_per[c] = cper; m_sh_mode[c] = cos; m_pend[c] = 1;
        end
      end
    end
    m_strobe = nstr;
    m_ready  = !acc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int per, input bit os, input bit arm);
    if (!m_ready) step();
    cv = 1'b1; cch = CW'(ch); cper = W'(per); cos = os; carm = arm;
    step();
    cv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = '1; cv = 0; cch = '0; cper = '0; cos = 0; carm = 0;
    model_reset();
    #3;
    n_chk++;
    if (strobe !== '0 || done !== '0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial strobe=%b done=%b ready=%b want 0/0/0", strobe, done, cfg_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    n_chk++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_release got %b want 0", cfg_ready);
    end
    step();
    n_chk++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise got %b want 1", cfg_ready);
    end
    cfg_write(0, 3, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (strobe !== m_strobe || done !== m_done || cfg_ready !== m_ready) begin
        n_fail++;
        $display("FAIL reset_pre cyc=%0d strobe=%b/%b done=%b/%b ready=%b/%b",
                 cyc, strobe, m_strobe, done, m_done, cfg_ready, m_ready);
      end
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (strobe !== '0 || done !== '0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async strobe=%b done=%b ready=%b want 0/0/0", strobe, done, cfg_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (strobe !== '0 || done !== '0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held strobe=%b done=%b ready=%b want 0/0/0", strobe, done, cfg_ready);
    end
    rst = 1'b1;
    model_reset();
    en = '0;
    step();
    n_chk++;
    if (cfg_ready !== 1'b1 || strobe !== '0) begin
      n_fail++;
      $display("FAIL reset_rerelease ready=%b strobe=%b want 1/0", cfg_ready, strobe);
    end
  endtask

  task automatic test_periodic();
    int base;
    int exp_q[$];
    exp_q = '{5, 10, 15};
    en = 4'b0001;
    cfg_write(0, 5, 0, 1);
    base = cyc;
    q.delete();
    for (int k = 0; k < 16; k++) begin
      step();
      n_chk++;
      if (strobe !== m_strobe || done !== m_done || cfg_ready !== m_ready) begin
        n_fail++;
        $display("FAIL periodic_model cyc=%0d strobe=%b/%b done=%b/%b", cyc, strobe, m_strobe,
                 done, m_done);
      end
      if (strobe[0]) q.push_back(cyc - base);
    end
    n_chk++;
    if (q.size() != exp_q.size() || q[0] != exp_q[0] || q[1] != exp_q[1] || q[2] != exp_q[2]) begin
      n_fail++;
      $display("FAIL periodic_times got %p want %p", q, exp_q);
    end
  endtask

  task automatic test_gapped();
    int base;
    en = '0;
    cfg_write(0, 0, 0, 1);
    cfg_write(1, 3, 0, 1);
    base = cyc;
    q.delete();
    for (int k = 1; k <= 14; k++) begin
      en = (k % 2 == 1) ? 4'b1111 : 4'b0000;
      step();
      n_chk++;
      if (strobe !== m_strobe || (strobe & 4'b1101) !== 4'b0000) begin
        n_fail++;
        $display("FAIL gapped_model cyc=%0d strobe=%b want %b", cyc, strobe, m_strobe);
      end
      if (strobe[1]) q.push_back(cyc - base);
    end
    n_chk++;
    if (q.size() != 2 || q[0] != 5 || q[1] != 11) begin
      n_fail++;
      $display("FAIL gapped_times got %p want 5,11", q);
    end
  endtask

  task automatic test_shadow();
    int base;
    int exp_q[$];
    exp_q = '{8, 11, 14, 17};
    en = 4'b0001;
    cfg_write(0, 8, 0, 1);
    base = cyc;
    q.delete();
    step();
    cfg_write(0, 3, 0, 0);
    while (cyc - base < 18) begin
      step();
      n_chk++;
      if (strobe !== m_strobe || done !== m_done || cfg_ready !== m_ready) begin
        n_fail++;
        $display("FAIL shadow_model cyc=%0d strobe=%b/%b", cyc, strobe, m_strobe);
      end
      if (strobe[0]) q.push_back(cyc - base);
    end
    n_chk++;
    if (q.size() != 4 || q[0] != exp_q[0] || q[1] != exp_q[1] || q[2] != exp_q[2] ||
        q[3] != exp_q[3]) begin
      n_fail++;
      $display("FAIL shadow_times got %p want %p", q, exp_q);
    end
  endtask

  task automatic test_oneshot();
    int base;
    en = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      cfg_write(2, 4, 1, 1);
      n_chk++;
      if (done[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL oneshot_arm_clears_done round=%0d got %b want 0", r, done[2]);
      end
      base = cyc;
      q.delete();
      for (int k = 0; k < 10; k++) begin
        step();
        n_chk++;
        if (strobe !== m_strobe || done !== m_done) begin
          n_fail++;
          $display("FAIL oneshot_model cyc=%0d strobe=%b/%b done=%b/%b", cyc, strobe, m_strobe,
                   done, m_done);
        end
        if (strobe[2]) q.push_back(cyc - base);
      end
      n_chk++;
      if (q.size() != 1 || q[0] != 4 || done[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL oneshot_single round=%0d got %p done=%b want 4 done=1", r, q, done[2]);
      end
    end
  endtask

  task automatic test_edges();
    int highs, base;
    en = 4'b1000;
    cfg_write(3, 1, 0, 1);
    highs = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (strobe[3]) highs++;
    end
    n_chk++;
    if (highs != 6) begin
      n_fail++;
      $display("FAIL edge_period1 highs=%0d want 6", highs);
    end
    cfg_write(3, 0, 0, 1);
    highs = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (strobe[3]) highs++;
    end
    n_chk++;
    if (highs != 0 || strobe !== m_strobe) begin
      n_fail++;
      $display("FAIL edge_period0 highs=%0d want 0", highs);
    end
    en = 4'b0010;
    cfg_write(1, 3, 0, 1);
    step();
    step();
    cfg_write(1, 3, 0, 1);
    n_chk++;
    if (strobe[1] !== 1'b0 || strobe !== m_strobe) begin
      n_fail++;
      $display("FAIL edge_arm_vs_terminal strobe=%b want %b", strobe, m_strobe);
    end
    base = cyc;
    q.delete();
    for (int k = 0; k < 8; k++) begin
      step();
      if (strobe[1]) q.push_back(cyc - base);
    end
    n_chk++;
    if (q.size() != 2 || q[0] != 3 || q[1] != 6) begin
      n_fail++;
      $display("FAIL edge_restart_times got %p want 3,6", q);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      en   = CH'($urandom);
      cv   = ($urandom_range(0, 2) == 0);
      cch  = CW'($urandom_range(0, CH - 1));
      cper = W'($urandom_range(0, 6));
      cos  = 1'($urandom_range(0, 1));
      carm = 1'($urandom_range(0, 1));
      step();
      n_chk++;
      if (strobe !== m_strobe || done !== m_done || cfg_ready !== m_ready) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d strobe=%b/%b done=%b/%b ready=%b/%b",
                 cyc, strobe, m_strobe, done, m_done, cfg_ready, m_ready);
      end
    end
    cv = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    test_reset();
    test_periodic();
    test_gapped();
    test_shadow();
    test_oneshot();
    test_edges();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
